// File: rtl/uart_rx_8n1_if.sv
// Byte-stream handshake between the UART receiver and its consumer.
//   data  : received byte, stable while valid is high
//   valid : holding register holds an unconsumed byte
//   ready : consumer takes data on any cycle with valid && ready
// master = the receiver (drives data/valid), slave = the consumer.
interface uart_rx_8n1_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: synchronises rx, recovers start/8 data/stop frames
// and presents bytes through a one-deep holding register.
//   clk       : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   rx        : raw serial line, idle high, asynchronous to clk
//   out_if    : data/valid/ready byte handshake (master side)
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a completed byte is dropped
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 139
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    uart_rx_8n1_if.master        out_if,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             sync1_q, rxs;
    logic             expire;
    logic             load;

    // Two-flop synchroniser; reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            sync1_q <= rx;
            rxs     <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign expire = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = expire ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                // Half-bit wait lands the start check mid-bit.
                if (!rxs) begin
                    cnt_d   = HALF_M1;
                    state_d = START;
                end
            end
            START: begin
                if (expire) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = BIT_M1;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Shift in from the top so the first (LSB) bit ends at bit 0.
                if (expire) begin
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = BIT_M1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (expire) begin
                    if (rxs) begin
                        load    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before another frame starts.
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A load wins over a plain consume; a consume in the load cycle
        // frees the slot so the new byte replaces the old one.
        if (load) begin
            if (!valid_q || out_if.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end
    end

    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;
    assign frame_err    = fe_q;
    assign overrun      = ov_q;
endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: one instance at 8 clocks/bit for the
// functional scenarios and one at 139 clocks/bit for baud-tolerance.
module tb_uart_rx_8n1;
    localparam int C8   = 8;
    localparam int C139 = 139;
    localparam int LAT8 = 3 + C8 / 2 + 9 * C8;  // rx drive edge -> valid rise

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx8 = 1'b1;
    logic rx139 = 1'b1;
    logic fe8, ov8, fe139, ov139;

    uart_rx_8n1_if u_if8 ();
    uart_rx_8n1_if u_if139 ();

    uart_rx_8n1 #(.CLKS_PER_BIT(C8)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx8), .out_if(u_if8.master),
        .frame_err(fe8), .overrun(ov8)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(C139)) dut139 (
        .clk(clk), .reset_n(reset_n), .rx(rx139), .out_if(u_if139.master),
        .frame_err(fe139), .overrun(ov139)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Negedge monitors
    int         rise_cnt = 0, rise_cyc = 0, fe_cnt = 0, ov_cnt = 0;
    int         fe139_cnt = 0, ov139_cnt = 0;
    logic       vprev = 1'b0;
    logic [7:0] hs_q[$];
    int         start_cyc = 0;

    always @(negedge clk) begin
        if (u_if8.valid && !vprev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        vprev = u_if8.valid;
        if (fe8) fe_cnt++;
        if (ov8) ov_cnt++;
        if (u_if8.valid && u_if8.ready) hs_q.push_back(u_if8.data);
        if (fe139) fe139_cnt++;
        if (ov139) ov139_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller sits at posedge+1; drives start, 8 data bits LSB first, stop.
    task automatic send(input int which, input logic [7:0] b, input logic stopb, input int len);
        logic [9:0] bits;
        bits = {stopb, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            if (which == 0) rx8 = bits[i];
            else            rx139 = bits[i];
            tick(len);
        end
    endtask

    int base_r, base_fe, base_ov, base_hs;

    task automatic snap();
        base_r  = rise_cnt;
        base_fe = fe_cnt;
        base_ov = ov_cnt;
        base_hs = hs_q.size();
    endtask

    initial begin
        u_if8.ready   = 1'b0;
        u_if139.ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(u_if8.valid), 0);
        check("rst_data", 32'(u_if8.data), 0);
        check("rst_fe", 32'(fe8), 0);
        check("rst_ov", 32'(ov8), 0);
        reset_n = 1'b1;
        tick(3);

        // 0xA5 with ready low, then consume
        snap();
        send(0, 8'hA5, 1'b1, C8);
        tick(2);
        check("a5_valid", 32'(u_if8.valid), 1);
        check("a5_data", 32'(u_if8.data), 32'hA5);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT8));
        u_if8.ready = 1'b1;
        tick(1);
        check("a5_consumed", 32'(u_if8.valid), 0);

        // Back-to-back 0x00, 0xFF with ready high
        snap();
        send(0, 8'h00, 1'b1, C8);
        send(0, 8'hFF, 1'b1, C8);
        tick(10);
        check("b2b_count", 32'(hs_q.size() - base_hs), 2);
        check("b2b_first", 32'(hs_q[base_hs]), 32'h00);
        check("b2b_second", 32'(hs_q[base_hs + 1]), 32'hFF);
        check("b2b_fe", 32'(fe_cnt - base_fe), 0);
        check("b2b_ov", 32'(ov_cnt - base_ov), 0);

        // False start: 3 low cycles
        snap();
        rx8 = 1'b0;
        tick(3);
        rx8 = 1'b1;
        tick(30);
        check("false_valid", 32'(rise_cnt - base_r), 0);
        check("false_fe", 32'(fe_cnt - base_fe), 0);
        check("false_idle", 32'(dut.state_q), 0);

        // Framing error then held-low line
        snap();
        send(0, 8'h3C, 1'b0, C8);
        tick(40);
        check("fe_break", 32'(dut.state_q), 4);
        rx8 = 1'b1;
        tick(5);
        check("fe_count", 32'(fe_cnt - base_fe), 1);
        check("fe_novalid", 32'(rise_cnt - base_r), 0);
        check("fe_idle", 32'(dut.state_q), 0);

        // Overrun: 0x11 then 0x22 with ready low
        u_if8.ready = 1'b0;
        snap();
        send(0, 8'h11, 1'b1, C8);
        send(0, 8'h22, 1'b1, C8);
        tick(5);
        check("ovr_count", 32'(ov_cnt - base_ov), 1);
        check("ovr_data", 32'(u_if8.data), 32'h11);
        check("ovr_valid", 32'(u_if8.valid), 1);
        check("ovr_fe", 32'(fe_cnt - base_fe), 0);

        // Ready exactly on the 0x22 load cycle
        u_if8.ready = 1'b1;
        tick(1);
        u_if8.ready = 1'b0;
        tick(3);
        send(0, 8'h11, 1'b1, C8);
        tick(3);
        snap();
        fork
            send(0, 8'h22, 1'b1, C8);
            begin
                tick(LAT8 - 1);
                u_if8.ready = 1'b1;
                tick(1);
                u_if8.ready = 1'b0;
            end
        join
        tick(5);
        check("ld_ov", 32'(ov_cnt - base_ov), 0);
        check("ld_data", 32'(u_if8.data), 32'h22);
        check("ld_valid", 32'(u_if8.valid), 1);

        // Reset during bit 1 of 0x5A (bit0=0, bit1=1), held byte discarded
        rx8 = 1'b0;
        tick(2 * C8);
        rx8 = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("rst2_valid", 32'(u_if8.valid), 0);
        check("rst2_data", 32'(u_if8.data), 0);
        tick(2);
        reset_n = 1'b1;
        tick(20);
        check("rst2_idle", 32'(dut.state_q), 0);
        snap();
        send(0, 8'h81, 1'b1, C8);
        tick(3);
        check("post_rst_data", 32'(u_if8.data), 32'h81);
        check("post_rst_valid", 32'(u_if8.valid), 1);
        check("post_rst_lat", 32'(rise_cyc - start_cyc), 32'(LAT8));

        // 139 clocks/bit, transmitter 2% slow then 2% fast
        send(1, 8'h55, 1'b1, 142);
        tick(20);
        check("slow_valid", 32'(u_if139.valid), 1);
        check("slow_data", 32'(u_if139.data), 32'h55);
        u_if139.ready = 1'b1;
        tick(1);
        u_if139.ready = 1'b0;
        tick(5);
        send(1, 8'h55, 1'b1, 136);
        tick(20);
        check("fast_valid", 32'(u_if139.valid), 1);
        check("fast_data", 32'(u_if139.data), 32'h55);
        check("b139_fe", 32'(fe139_cnt), 0);
        check("b139_ov", 32'(ov139_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_8n1.md
# uart_rx_8n1

Serial receive front end that sits between the `rx` pin and the `top` core. It synchronises the asynchronous `rx` line and recovers 8N1 frames: one start bit, eight data bits LSB first, one stop bit, no parity. Received bytes are presented on a valid/ready handshake backed by a one-deep holding register. Framing errors and overruns are flagged with single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 139: clock cycles per bit period. 139 gives 115200 baud at 16 MHz. Legal range 4..65535.
- `clk` input 1: sole clock; all state is updated on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `rx` input 1: raw serial line, idle high, asynchronous to `clk`.
- `data` output 8: received byte; stable while `valid`=1.
- `valid` output 1: holding register contains an unconsumed byte.
- `ready` input 1: consumer accepts `data` in any cycle where `valid`=1 and `ready`=1.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped.

## Operation
- Synchroniser: two flops on `rx`, both reset to 1. The second flop output is `rxs`. All decisions use `rxs`.
- Baud counter: width is ceil(log2(CLKS_PER_BIT)). Let H = floor(CLKS_PER_BIT/2).
- FSM states and transitions:
  - IDLE: when `rxs`=0, load the counter with H-1 and go to START.
  - START: when the counter reaches 0, sample `rxs`.
    - If `rxs`=1, this is a false start; return to IDLE.
    - Otherwise reload the counter with CLKS_PER_BIT-1, clear the bit index, and go to DATA.
  - DATA: on each counter expiry, shift `rxs` into the shift register MSB-first-in, so the first received bit ends at bit 0. Reload the counter.
    - After the 8th sample, go to STOP.
  - STOP: on counter expiry, sample `rxs`.
    - If 1, attempt a load into the holding register and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Holding register load:
  - If `valid`=0, or `valid`=1 and `ready`=1 in the same cycle, load `data` and set `valid`=1.
  - Otherwise keep the old byte, leave `valid`=1, and pulse `overrun`.
- Consume: `valid`=1 and `ready`=1 with no simultaneous load clears `valid` on the next edge.
- `ready` is ignored while `valid`=0.
- Reset values: FSM IDLE, counter 0, shift register 0, `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, both synchroniser flops 1.
- Reset asserted mid-frame aborts the frame and discards any held byte. After release, reception resumes only at the next falling edge seen in IDLE.

## Timing
- The synchroniser adds 2 cycles of latency from `rx` to `rxs`.
- Let t = the first cycle `rxs`=0 while in IDLE.
  - Start bit checked at t+H.
  - Data bit i (0..7) sampled at t+H+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled at t+H+9·CLKS_PER_BIT.
- `valid` rises, or `frame_err`/`overrun` pulses, on the edge following the stop sample.
- Back-to-back frames are supported. IDLE is re-entered H cycles before the stop bit ends, so a start edge arriving immediately after the stop bit is caught.
- `frame_err` and `overrun` are registered outputs, high for exactly one cycle, and never high together.
- Throughput is one byte per 10·CLKS_PER_BIT cycles; `ready` may be held high permanently.

## Test plan
(All scenarios use CLKS_PER_BIT=8 unless stated.)
- Send 0xA5 with `ready`=0.
  - `valid` rises 1 cycle after the stop sample with `data`=0xA5.
  - Raise `ready`; `valid`=0 on the next edge.
- Send 0x00 then 0xFF back-to-back with `ready`=1 throughout.
  - Two `valid` cycles occur, carrying 0x00 then 0xFF.
  - `frame_err`=0 and `overrun`=0 throughout.
- Pulse `rx` low for 3 cycles.
  - False start: no `valid` and no `frame_err`; FSM back in IDLE.
- Send 0x3C with the stop bit driven low, then hold `rx` low for 40 cycles.
  - Exactly one `frame_err` pulse; `valid` stays 0.
  - No further frames until `rx` returns high.
- Send 0x11 then 0x22 with `ready`=0.
  - One `overrun` pulse; `data` stays 0x11.
- Repeat with `ready` asserted exactly on the 0x22 load cycle.
  - No `overrun`; `data`=0x22 and `valid` stays 1.
- Assert `reset_n`=0 mid-data-bit of 0x5A, hold 2 cycles, release.
  - `valid`=0 and `data`=0x00.
  - The next full frame 0x81 is received correctly.
- Run CLKS_PER_BIT=139 with the transmitter at ±2% baud error, sending 0x55.
  - Byte received correctly with no errors.
